sm_ptr_alloc: RTL and testbench

Parametrised pointer allocator for the shared-memory subsystem. It owns the free list of `2**PTR_WIDTH` buffer slots and serves allocation requests from `CHANNELS` writers with round-robin arbitration. Each allocation returns a pointer with code `WR_OK`, or `WR_ERR_NO_SPACE` when the list is empty. It also accepts pointer releases (the CLEAR path) and rejects double frees. It sits between the writer ports and the shared data RAM, replacing the fixed 8-bit, single-writer pointer scheme.

---
 rtl/sm_ptr_alloc.sv | 186 ++++++++++++++++++
 tb/tb_sm_ptr_alloc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ptr_alloc.sv
// sm_ptr_alloc: free-list pointer allocator for the shared-memory subsystem.
//
// Owns a free list of 2**PTR_WIDTH buffer slots (circular FIFO plus a "used"
// bitmap). It serves allocation requests from CHANNELS writers with
// round-robin arbitration and accepts pointer releases. A release of a
// pointer that is not currently allocated is rejected as a double free.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   alloc_req_i           per-channel allocation request (level)
//   alloc_gnt_o           one-hot grant (combinational); handshake = req & gnt
//   alloc_res_valid_o     registered result strobe, one cycle after the grant
//   alloc_res_ch_o        channel the result belongs to
//   alloc_res_code_o      WR_OK or WR_ERR_NO_SPACE
//   alloc_res_ptr_o       allocated pointer (0 on WR_ERR_NO_SPACE)
//   free_valid_i/ptr_i    pointer release request
//   free_ready_o          releases accepted (RUN state)
//   free_err_o            one-cycle pulse on a release of an unallocated pointer
//   free_cnt_o            pointers currently in the free list
//   init_done_o           free list initialised (RUN state)

package sm;
    typedef enum logic [0:0] {
        WR_OK           = 1'b0,
        WR_ERR_NO_SPACE = 1'b1
    } sm_res_code_t;
endpackage

module sm_ptr_alloc #(
    parameter int PTR_WIDTH = 8,
    parameter int CHANNELS  = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CHANNELS-1:0]   alloc_req_i,
    output logic [CHANNELS-1:0]   alloc_gnt_o,
    output logic                  alloc_res_valid_o,
    output logic [CH_W-1:0]       alloc_res_ch_o,
    output sm::sm_res_code_t      alloc_res_code_o,
    output logic [PTR_WIDTH-1:0]  alloc_res_ptr_o,
    input  logic                  free_valid_i,
    input  logic [PTR_WIDTH-1:0]  free_ptr_i,
    output logic                  free_ready_o,
    output logic                  free_err_o,
    output logic [PTR_WIDTH:0]    free_cnt_o,
    output logic                  init_done_o
);

    localparam int          DEPTH = 2 ** PTR_WIDTH;
    localparam int          CNT_W = PTR_WIDTH + 1;
    localparam int unsigned NCH   = CHANNELS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_WIDTH-1:0] init_k_q;
    logic [PTR_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_idx_q, wr_idx_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]     used_q, used_d;
    logic [CH_W-1:0]      last_q;

    logic [CHANNELS-1:0]  gnt;
    logic [CH_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic                 pop, push, rel_err;
    logic [PTR_WIDTH-1:0] pop_ptr;

    // ---------------------------------------------------------------
    // FSM next state: INIT walks k over every slot, then RUN forever.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_k_q == PTR_WIDTH'(DEPTH - 1))
            state_d = ST_RUN;
    end

    // ---------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last grant.
    // ---------------------------------------------------------------
    always_comb begin
        logic [CH_W-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (state_q == ST_RUN) begin
            for (int unsigned i = 1; i <= NCH; i++) begin
                cand = CH_W'((32'(last_q) + i) % NCH);
                if (!gnt_any && alloc_req_i[cand]) begin
                    gnt_any      = 1'b1;
                    gnt_idx      = cand;
                    gnt[cand]    = 1'b1;
                end
            end
        end
    end

    assign alloc_gnt_o = gnt;

    // ---------------------------------------------------------------
    // Pop/push decisions use pre-cycle count and bitmap (no bypass).
    // A pointer popped this cycle still reads used=0, so releasing it
    // in the same cycle is flagged as a double free.
    // ---------------------------------------------------------------
    always_comb begin
        pop     = gnt_any && (cnt_q != '0);
        pop_ptr = fifo_mem[rd_idx_q];
        push    = free_valid_i && (state_q == ST_RUN) && used_q[free_ptr_i];
        rel_err = free_valid_i && (state_q == ST_RUN) && !used_q[free_ptr_i];

        used_d = used_q;
        if (pop)
            used_d[pop_ptr] = 1'b1;
        if (push)
            used_d[free_ptr_i] = 1'b0;

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // ---------------------------------------------------------------
    // Control and result registers.
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_INIT;
            init_k_q          <= '0;
            rd_idx_q          <= '0;
            wr_idx_q          <= '0;
            cnt_q             <= '0;
            used_q            <= '0;
            last_q            <= CH_W'(CHANNELS - 1);
            alloc_res_valid_o <= 1'b0;
            alloc_res_ch_o    <= '0;
            alloc_res_code_o  <= sm::WR_OK;
            alloc_res_ptr_o   <= '0;
            free_err_o        <= 1'b0;
        end else begin
            state_q           <= state_d;
            alloc_res_valid_o <= gnt_any;
            free_err_o        <= rel_err;
            if (state_q == ST_INIT) begin
                init_k_q <= init_k_q + PTR_WIDTH'(1);
                // FIFO is full after init, so both indices wrap back to 0.
                if (state_d == ST_RUN)
                    cnt_q <= CNT_W'(DEPTH);
            end else begin
                if (gnt_any) begin
                    last_q           <= gnt_idx;
                    alloc_res_ch_o   <= gnt_idx;
                    alloc_res_code_o <= pop ? sm::WR_OK : sm::WR_ERR_NO_SPACE;
                    alloc_res_ptr_o  <= pop ? pop_ptr : '0;
                end
                if (pop)
                    rd_idx_q <= rd_idx_q + PTR_WIDTH'(1);
                if (push)
                    wr_idx_q <= wr_idx_q + PTR_WIDTH'(1);
                used_q <= used_d;
                cnt_q  <= cnt_d;
            end
        end
    end

    // Free-list storage; contents are rebuilt by INIT so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT)
                fifo_mem[init_k_q] <= init_k_q;
            else if (push)
                fifo_mem[wr_idx_q] <= free_ptr_i;
        end
    end

    assign free_ready_o = (state_q == ST_RUN);
    assign init_done_o  = (state_q == ST_RUN);
    assign free_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sm_ptr_alloc.sv
// Self-checking bench for sm_ptr_alloc (PTR_WIDTH=8, CHANNELS=4).
// The reference model keeps the free list as a queue of integers and the
// allocation state as a bit array; expected per-cycle responses go into a
// scoreboard queue that a negedge monitor pops and compares.

module tb_sm_ptr_alloc;

    localparam int PW    = 8;
    localparam int CH    = 4;
    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     req = '0;
    logic              fv  = 1'b0;
    logic [PW-1:0]     fp  = '0;

    logic [CH-1:0]     gnt;
    logic              res_valid;
    logic [1:0]        res_ch;
    sm::sm_res_code_t  res_code;
    logic [PW-1:0]     res_ptr;
    logic              free_ready;
    logic              free_err;
    logic [PW:0]       free_cnt;
    logic              init_done;

    sm_ptr_alloc #(.PTR_WIDTH(PW), .CHANNELS(CH)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .alloc_req_i       (req),
        .alloc_gnt_o       (gnt),
        .alloc_res_valid_o (res_valid),
        .alloc_res_ch_o    (res_ch),
        .alloc_res_code_o  (res_code),
        .alloc_res_ptr_o   (res_ptr),
        .free_valid_i      (fv),
        .free_ptr_i        (fp),
        .free_ready_o      (free_ready),
        .free_err_o        (free_err),
        .free_cnt_o        (free_cnt),
        .init_done_o       (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int ch;
        int code;
        int ptr;
        bit err;
        int cnt;
    } exp_t;

    exp_t st_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    int   free_q[$];
    bit   used_m[DEPTH];
    int   last_m;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        free_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            free_q.push_back(i);
            used_m[i] = 1'b0;
        end
        last_m = CH - 1;
    endfunction

    // Monitor: one scoreboard entry per driven RUN cycle.
    exp_t e_mon;
    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() == 0) begin
                if (res_valid)
                    chk("unexpected_result", 1, 0);
            end else begin
                e_mon = st_q.pop_front();
                chk("res_valid", int'(res_valid), int'(e_mon.v));
                if (e_mon.v && res_valid) begin
                    chk("res_ch", int'(res_ch), e_mon.ch);
                    chk("res_code", int'(res_code), e_mon.code);
                    chk("res_ptr", int'(res_ptr), e_mon.ptr);
                end
                chk("free_err", int'(free_err), int'(e_mon.err));
                chk("free_cnt", int'(free_cnt), e_mon.cnt);
            end
        end
    end

    // One RUN cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [CH-1:0] r, input bit v, input int p);
        exp_t e;
        int   g;
        bit   rel_ok;
        int   sz;
        g   = -1;
        req = r;
        fv  = v;
        fp  = p[PW-1:0];
        for (int i = 1; i <= CH; i++) begin
            int c;
            c = (last_m + i) % CH;
            if (g < 0 && r[c])
                g = c;
        end
        @(negedge clk);
        chk("grant", int'(gnt), (g < 0) ? 0 : (1 << g));
        rel_ok = v && used_m[p];
        sz     = free_q.size();
        e.v    = (g >= 0);
        e.ch   = (g < 0) ? 0 : g;
        e.code = int'(sm::WR_OK);
        e.ptr  = 0;
        if (g >= 0) begin
            last_m = g;
            if (sz > 0) begin
                e.ptr = free_q.pop_front();
                used_m[e.ptr] = 1'b1;
            end else begin
                e.code = int'(sm::WR_ERR_NO_SPACE);
            end
        end
        if (rel_ok) begin
            free_q.push_back(p);
            used_m[p] = 1'b0;
        end
        e.err = v && !rel_ok;
        e.cnt = free_q.size();
        @(posedge clk);
        #1;
        st_q.push_back(e);
    endtask

    task automatic check_reset_values();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_ch", int'(res_ch), 0);
        chk("rst_res_code", int'(res_code), int'(sm::WR_OK));
        chk("rst_res_ptr", int'(res_ptr), 0);
        chk("rst_free_ready", int'(free_ready), 0);
        chk("rst_free_err", int'(free_err), 0);
        chk("rst_free_cnt", int'(free_cnt), 0);
        chk("rst_init_done", int'(init_done), 0);
    endtask

    // Release reset and run through INIT with requests and releases asserted;
    // none of them may take effect.
    task automatic run_init();
        int edges;
        edges = 0;
        req = '1;
        fv  = 1'b1;
        fp  = 8'd3;
        rst = 1'b0;
        while (!init_done && edges < 1000) begin
            @(negedge clk);
            chk("init_gnt", int'(gnt), 0);
            chk("init_free_err", int'(free_err), 0);
            @(posedge clk);
            edges++;
            #1;
        end
        chk("init_edges", edges, DEPTH);
        chk("init_free_cnt", int'(free_cnt), DEPTH);
        chk("init_free_ready", int'(free_ready), 1);
        req = '0;
        fv  = 1'b0;
        model_reset();
        st_q.delete();
        mon_en = 1'b1;
        if (edges >= 1000) begin
            $display("FAIL init_timeout: init_done_o never rose");
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $fatal(1);
        end
    endtask

    function automatic int pick_ptr();
        int s;
        s = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 4) != 0) begin
            for (int i = 0; i < DEPTH; i++)
                if (used_m[(s + i) % DEPTH])
                    return (s + i) % DEPTH;
        end
        return s;
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic [CH-1:0] r;
            bit v;
            r = CH'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            step(r, v, pick_ptr());
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        run_init();

        // Channel 0: three consecutive allocations -> 0,1,2
        for (int i = 0; i < 3; i++)
            step(4'b0001, 1'b0, 0);

        // All channels continuously: grants rotate 0..3 twice
        for (int i = 0; i < 8; i++)
            step(4'b1111, 1'b0, 0);

        random_phase(300);

        // Drain the list, then one more -> no space
        for (int i = 0; i < 300 && free_q.size() > 0; i++)
            step(4'b0010, 1'b0, 0);
        step(4'b0010, 1'b0, 0);
        // Release 5 concurrent with alloc: alloc sees empty list
        step(4'b0010, 1'b1, 5);
        // Next allocation gets ptr 5
        step(4'b0010, 1'b0, 0);
        // Release 7 twice: second is a double free
        step(4'b0000, 1'b1, 7);
        step(4'b0000, 1'b1, 7);

        random_phase(150);

        // Mid-stream reset with 10 pointers allocated and a request in flight
        rst = 1'b1;
        req = '1;
        repeat (3) @(posedge clk);
        #1;
        run_init();
        for (int i = 0; i < 10; i++)
            step(4'b0100, 1'b0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        st_q.delete();
        req = '1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values();
        run_init();
        step(4'b0001, 1'b0, 0);

        random_phase(100);

        req = '0;
        fv  = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", st_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
